pipeline_operand_feeder: RTL and testbench
==========================================

Name: pipeline_operand_feeder

Overview:
Upstream stage of the arithmetic pipeline. Accepts operand triplets (A, B, C) from a producer over a valid/ready handshake and buffers them in a small FIFO. Issues one triplet per cycle to the pipeline's A/B/C inputs, inserting zero bubbles when empty. Honours the pipeline's stall so no operand is lost or duplicated while the pipeline is frozen.

Parameters:
INP_WIDTH, 2, width of each operand (matches pipeline INP_WIDTH)
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_WIDTH, $clog2(DEPTH)+1, width of occupancy count (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
stall  input  1  pipeline freeze; same signal driven to the pipeline's stall port
in_valid  input  1  producer has a triplet on in_a/in_b/in_c
in_ready  output  1  feeder accepts a triplet this cycle
in_a  input  INP_WIDTH  operand A from producer
in_b  input  INP_WIDTH  operand B from producer
in_c  input  INP_WIDTH  operand C from producer
A  output  INP_WIDTH  registered operand A to pipeline
B  output  INP_WIDTH  registered operand B to pipeline
C  output  INP_WIDTH  registered operand C to pipeline
out_valid  output  1  A/B/C hold a real triplet (0 = bubble)
count  output  CNT_WIDTH  current FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (rst=1 at a clock edge): wr_ptr=0, rd_ptr=0, count=0, A=B=C=0, out_valid=0. FIFO storage is not cleared. Reset mid-operation discards all buffered triplets.
- in_ready = !rst && (count != DEPTH). It is combinational from registered state and does not depend on in_valid.
- Push = in_valid && in_ready. Triplet is written at mem[wr_ptr], and wr_ptr advances modulo DEPTH.
- Full FIFO: in_ready=0 even if a pop occurs in the same cycle. There is no pass-through when full.
- Pop/issue when stall=0:
  - count>0: A/B/C <= mem[rd_ptr], out_valid<=1, rd_ptr advances modulo DEPTH.
  - count==0: A=B=C<=0, out_valid<=0 (bubble).
- stall=1: A/B/C/out_valid hold their values, no pop, rd_ptr unchanged. Pushes still proceed if in_ready.
- count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
- No empty bypass. A triplet pushed at edge N is issued at edge N+1 at the earliest, so A/B/C are valid after edge N+1. Minimum latency is 2 cycles from presentation to output.
- Ordering is strict FIFO. No triplet is dropped, duplicated or reordered across any stall pattern.
- Pointers are log2(DEPTH) bits and wrap naturally.

Decomposition:
- Package pipeline_pkg holds:
  - typedef operand_t (logic [INP_WIDTH-1:0])
  - struct triplet_t {a, b, c}
  - default width constants shared with the pipeline
- One natural sub-module, feeder_fifo_mem: DEPTH x 3*INP_WIDTH register array with write port and async read port.
- Pointer, count and output-register logic stay in the top.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then in_valid=0 -> in_ready=1, count=0, A=B=C=0, out_valid=0 every cycle.
- Single triplet: push (1,1,1) at edge N with stall=0 -> A=B=C=1, out_valid=1 after edge N+1. Bubble (0,0,0, out_valid=0) after edge N+2. count returns to 0.
- Fill to full: stall=1, push (0,0,0), (1,1,1), (2,2,2), (3,3,3) -> count=4, in_ready=0. A fifth push with in_valid=1 is not accepted. Release stall -> outputs 0,1,2,3 in order on consecutive cycles.
- Stall mid-stream: streaming (3,1,2) then (2,2,2), stall=1 for 2 cycles after the first issue -> A/B/C hold (3,1,2) for 3 cycles total, then (2,2,2) appears. Nothing is lost or repeated.
- Simultaneous push/pop at count=2, stall=0 -> count stays 2, the oldest entry is issued, and the new entry is stored at wr_ptr.
- Wrap-around plus reset mid-operation: push/pop 10 triplets continuously (pointers wrap twice) and check order; assert rst with count=3 -> next cycle count=0, out_valid=0, in_ready=1 after rst falls.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and default widths for the arithmetic pipeline and its operand feeder.
package pipeline_pkg;

    localparam int INP_WIDTH_DEF = 2;
    localparam int DEPTH_DEF     = 4;

    typedef logic [INP_WIDTH_DEF-1:0] operand_t;

    // Packed layout {a, b, c} is the same order the feeder stores triplets in its FIFO.
    typedef struct packed {
        operand_t a;
        operand_t b;
        operand_t c;
    } triplet_t;

endpackage

// File: rtl/feeder_fifo_mem.sv
// Triplet storage for the operand feeder: one synchronous write port, one asynchronous read port.
module feeder_fifo_mem
    import pipeline_pkg::*;
#(
    parameter  int WIDTH = 3 * INP_WIDTH_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    // Storage is deliberately not reset; the pointers and count decide what is live.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipeline_operand_feeder.sv
// Buffers producer operand triplets in a small FIFO and issues one per cycle to the
// pipeline's A/B/C inputs, inserting zero bubbles when empty and freezing on stall.
module pipeline_operand_feeder
    import pipeline_pkg::*;
#(
    parameter  int INP_WIDTH = INP_WIDTH_DEF,
    parameter  int DEPTH     = DEPTH_DEF,
    localparam int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INP_WIDTH-1:0] in_a,
    input  logic [INP_WIDTH-1:0] in_b,
    input  logic [INP_WIDTH-1:0] in_c,
    output logic [INP_WIDTH-1:0] A,
    output logic [INP_WIDTH-1:0] B,
    output logic [INP_WIDTH-1:0] C,
    output logic                 out_valid,
    output logic [CNT_WIDTH-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int TW    = 3 * INP_WIDTH;

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [INP_WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic                 valid_q, valid_d;
    logic [TW-1:0]        rd_data;
    logic                 full, empty, push, pop;

    // Handshake: a triplet transfers on any rising edge where in_valid && in_ready;
    // in_ready depends only on registered occupancy (never on in_valid or a same-cycle pop).
    assign full     = (count_q == CNT_WIDTH'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !rst && !full;
    assign push     = in_valid && in_ready;
    assign pop      = !stall && !empty;

    feeder_fifo_mem #(
        .WIDTH(TW),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk_i  (clk),
        .we_i   (push),
        .waddr_i(wr_ptr_q),
        .wdata_i({in_a, in_b, in_c}),
        .raddr_i(rd_ptr_q),
        .rdata_o(rd_data)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        valid_d  = valid_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        // Output registers only move when the pipeline is not frozen.
        if (pop) begin
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
            {a_d, b_d, c_d}   = rd_data;
            valid_d           = 1'b1;
        end else if (!stall) begin
            a_d     = '0;
            b_d     = '0;
            c_d     = '0;
            valid_d = 1'b0;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            valid_q  <= valid_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign C         = c_q;
    assign out_valid = valid_q;
    assign count     = count_q;

endmodule

// File: tb/tb_pipeline_operand_feeder.sv
// Directed, table-driven bench for pipeline_operand_feeder (INP_WIDTH=2, DEPTH=4).
module tb_pipeline_operand_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_a = '0, in_b = '0, in_c = '0;
    logic [1:0] A, B, C;
    logic       out_valid;
    logic [2:0] count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pipeline_operand_feeder #(
        .INP_WIDTH(2),
        .DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .A(A), .B(B), .C(C),
        .out_valid(out_valid), .count(count)
    );

    // One row per cycle: inputs, in_ready expected before the edge, outputs expected after it.
    typedef struct packed {
        logic       rst;
        logic       stall;
        logic       vld;
        logic [5:0] abc;
        logic       rdy;
        logic [5:0] eabc;
        logic       ev;
        logic [2:0] ecnt;
    } vec_t;

    localparam int NVEC = 29;
    vec_t vecs [NVEC];
    logic [5:0] exp_q [$];

    function automatic vec_t mk(input logic r, input logic s, input logic v, input logic [5:0] abc,
                                input logic rdy, input logic [5:0] eabc, input logic ev,
                                input logic [2:0] ecnt);
        vec_t t;
        t.rst = r; t.stall = s; t.vld = v; t.abc = abc;
        t.rdy = rdy; t.eabc = eabc; t.ev = ev; t.ecnt = ecnt;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic v, input logic [5:0] abc);
        rst = r; stall = s; in_valid = v;
        {in_a, in_b, in_c} = abc;
    endtask

    task automatic check_out(input int idx, input logic [5:0] eabc, input logic ev, input logic [2:0] ecnt);
        check("abc", idx, {2'b00, A, B, C}, {2'b00, eabc});
        check("out_valid", idx, {7'd0, out_valid}, {7'd0, ev});
        check("count", idx, {5'd0, count}, {5'd0, ecnt});
    endtask

    task automatic apply(input vec_t v, input int idx);
        drive(v.rst, v.stall, v.vld, v.abc);
        #1;
        check("in_ready", idx, {7'd0, in_ready}, {7'd0, v.rdy});
        @(posedge clk);
        #1;
        check_out(idx, v.eabc, v.ev, v.ecnt);
    endtask

    initial begin
        // reset and idle
        vecs[0]  = mk(1, 0, 0, 6'o00, 0, 6'o00, 0, 0);
        vecs[1]  = mk(1, 0, 0, 6'o00, 0, 6'o00, 0, 0);
        vecs[2]  = mk(0, 0, 0, 6'o00, 1, 6'o00, 0, 0);
        vecs[3]  = mk(0, 0, 0, 6'o00, 1, 6'o00, 0, 0);
        // single triplet: two-cycle latency, then a bubble
        vecs[4]  = mk(0, 0, 1, {2'd1, 2'd1, 2'd1}, 1, 6'o00, 0, 1);
        vecs[5]  = mk(0, 0, 0, 6'o00, 1, {2'd1, 2'd1, 2'd1}, 1, 0);
        vecs[6]  = mk(0, 0, 0, 6'o00, 1, 6'o00, 0, 0);
        // fill to full under stall, fifth push refused, drain in order
        vecs[7]  = mk(0, 1, 1, {2'd0, 2'd0, 2'd0}, 1, 6'o00, 0, 1);
        vecs[8]  = mk(0, 1, 1, {2'd1, 2'd1, 2'd1}, 1, 6'o00, 0, 2);
        vecs[9]  = mk(0, 1, 1, {2'd2, 2'd2, 2'd2}, 1, 6'o00, 0, 3);
        vecs[10] = mk(0, 1, 1, {2'd3, 2'd3, 2'd3}, 1, 6'o00, 0, 4);
        vecs[11] = mk(0, 1, 1, {2'd0, 2'd1, 2'd2}, 0, 6'o00, 0, 4);
        vecs[12] = mk(0, 0, 1, {2'd1, 2'd2, 2'd3}, 0, {2'd0, 2'd0, 2'd0}, 1, 3);
        vecs[13] = mk(0, 0, 0, 6'o00, 1, {2'd1, 2'd1, 2'd1}, 1, 2);
        vecs[14] = mk(0, 0, 0, 6'o00, 1, {2'd2, 2'd2, 2'd2}, 1, 1);
        vecs[15] = mk(0, 0, 0, 6'o00, 1, {2'd3, 2'd3, 2'd3}, 1, 0);
        vecs[16] = mk(0, 0, 0, 6'o00, 1, 6'o00, 0, 0);
        // stall mid-stream: (3,1,2) held three cycles, then (2,2,2)
        vecs[17] = mk(0, 0, 1, {2'd3, 2'd1, 2'd2}, 1, 6'o00, 0, 1);
        vecs[18] = mk(0, 0, 1, {2'd2, 2'd2, 2'd2}, 1, {2'd3, 2'd1, 2'd2}, 1, 1);
        vecs[19] = mk(0, 1, 0, 6'o00, 1, {2'd3, 2'd1, 2'd2}, 1, 1);
        vecs[20] = mk(0, 1, 0, 6'o00, 1, {2'd3, 2'd1, 2'd2}, 1, 1);
        vecs[21] = mk(0, 0, 0, 6'o00, 1, {2'd2, 2'd2, 2'd2}, 1, 0);
        vecs[22] = mk(0, 0, 0, 6'o00, 1, 6'o00, 0, 0);
        // simultaneous push and pop at count 2
        vecs[23] = mk(0, 1, 1, {2'd1, 2'd2, 2'd3}, 1, 6'o00, 0, 1);
        vecs[24] = mk(0, 1, 1, {2'd2, 2'd3, 2'd0}, 1, 6'o00, 0, 2);
        vecs[25] = mk(0, 0, 1, {2'd3, 2'd0, 2'd1}, 1, {2'd1, 2'd2, 2'd3}, 1, 2);
        vecs[26] = mk(0, 0, 0, 6'o00, 1, {2'd2, 2'd3, 2'd0}, 1, 1);
        vecs[27] = mk(0, 0, 0, 6'o00, 1, {2'd3, 2'd0, 2'd1}, 1, 0);
        vecs[28] = mk(0, 0, 0, 6'o00, 1, 6'o00, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i], i);
        end

        // continuous push/pop of 10 triplets: pointers wrap more than twice
        for (int i = 0; i < 10; i++) begin
            logic [5:0] t;
            logic [5:0] e;
            t = {2'(i), 2'(i + 1), 2'(i + 2)};
            drive(0, 0, 1, t);
            #1;
            check("wrap_ready", i, {7'd0, in_ready}, 8'd1);
            @(posedge clk);
            #1;
            if (i == 0) begin
                check_out(100 + i, 6'o00, 0, 1);
            end else begin
                e = exp_q.pop_front();
                check_out(100 + i, e, 1, 1);
            end
            exp_q.push_back(t);
        end
        drive(0, 0, 0, 6'o00);
        @(posedge clk);
        #1;
        check_out(110, exp_q.pop_front(), 1, 0);
        check("wrap_q_empty", 110, 8'(exp_q.size()), 8'd0);

        // reset with three triplets buffered discards them all
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, {2'd3, 2'd3, 2'(i)});
            @(posedge clk);
            #1;
            check("pre_rst_count", 200 + i, {5'd0, count}, 8'(i + 1));
        end
        drive(1, 0, 1, {2'd2, 2'd2, 2'd2});
        #1;
        check("rst_ready", 210, {7'd0, in_ready}, 8'd0);
        @(posedge clk);
        #1;
        check_out(211, 6'o00, 0, 0);
        drive(0, 0, 0, 6'o00);
        #1;
        check("post_rst_ready", 212, {7'd0, in_ready}, 8'd1);
        @(posedge clk);
        #1;
        check_out(213, 6'o00, 0, 0);
        drive(0, 0, 1, {2'd1, 2'd2, 2'd3});
        @(posedge clk);
        #1;
        check_out(214, 6'o00, 0, 1);
        drive(0, 0, 0, 6'o00);
        @(posedge clk);
        #1;
        check_out(215, {2'd1, 2'd2, 2'd3}, 1, 0);
        @(posedge clk);
        #1;
        check_out(216, 6'o00, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
